cell_plot_queue: RTL



---
 rtl/cell_plot_pkg.sv | 16 +
 rtl/plot_fifo.sv | 36 +++
 rtl/cell_plot_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/cell_plot_pkg.sv
// cell_plot_pkg: shared widths, colours, FSM state and update record for cell_plot_queue
package cell_plot_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;
  localparam logic [COLOUR_W-1:0] ALIVE_C = 3'b111;
  localparam logic [COLOUR_W-1:0] DEAD_C = 3'b000;
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           alive;
  } update_t;
endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous FIFO of cell updates
// Ports: clock, reset_n (async active-low, pointers only), push/din, pop/dout (first-word
// fall-through), full, empty, count (occupancy).
module plot_fifo
  import cell_plot_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  update_t                  din,
  output update_t                  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  update_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, push};
      rp <= rp + {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clock)
    if (push) mem[wp[AW-1:0]] <= din;
  assign dout  = mem[rp[AW-1:0]];
  assign count = wp - rp;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/cell_plot_queue.sv
// cell_plot_queue: buffers cell updates and feeds vga_adapter one pixel per clock, with clear sweep
// Ports: clock, reset_n (async active-low); in_valid/in_ready/in_x/in_y/in_alive update input;
// clear_req screen-clear pulse; busy, range_err (sticky), fill status; x/y/colour/plot to vga_adapter.
// Build option: define CELL_PLOT_CLEAR_ON_RESET_EN to start a clear sweep automatically after reset.
module cell_plot_queue
  import cell_plot_pkg::*;
#(
  parameter int                    FIFO_DEPTH   = 16,
  parameter logic [COLOUR_W-1:0]   ALIVE_COLOUR = ALIVE_C,
  parameter logic [COLOUR_W-1:0]   DEAD_COLOUR  = DEAD_C,
  parameter int                    GRID_W       = GRID_W_DEF,
  parameter int                    GRID_H       = GRID_H_DEF
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [X_W-1:0]                in_x,
  input  logic [Y_W-1:0]                in_y,
  input  logic                          in_alive,
  input  logic                          clear_req,
  output logic                          busy,
  output logic                          range_err,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic [X_W-1:0]                x,
  output logic [Y_W-1:0]                y,
  output logic [COLOUR_W-1:0]           colour,
  output logic                          plot
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [X_W-1:0] XMAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(GRID_H - 1);
`ifdef CELL_PLOT_CLEAR_ON_RESET_EN
  localparam logic PEND_RST = 1'b1;
`else
  localparam logic PEND_RST = 1'b0;
`endif
  state_t state, nxt;
  update_t head;
  logic full, empty, push, pop, in_range, accept, pend, last_px, row_end, drain_done;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop),
    .din('{x: in_x, y: in_y, alive: in_alive}), .dout(head),
    .full(full), .empty(empty), .count(fill)
  );
  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign in_range   = in_x <= XMAX && in_y <= YMAX;
  // out-of-range updates are consumed but never stored
  assign push       = accept && in_range;
  assign pop        = state == DRAIN && !empty;
  assign row_end    = cx == XMAX;
  assign last_px    = row_end && cy == YMAX;
  // leave DRAIN in the same edge that pops the final entry
  assign drain_done = fill <= CW'(1) && !push;
  assign busy       = state != IDLE || !empty || pend;
  always_comb
    nxt = state == IDLE  ? ((clear_req || pend) ? CLEAR : (!empty ? DRAIN : IDLE)) :
          state == CLEAR ? (last_px ? (!empty ? DRAIN : IDLE) : CLEAR) :
                           (drain_done ? IDLE : DRAIN);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      pend      <= PEND_RST;
      range_err <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      x         <= '0;
      y         <= '0;
      colour    <= '0;
      plot      <= 1'b0;
    end else begin
      state     <= nxt;
      // a clear arriving mid-drain waits until queued updates are plotted
      pend      <= nxt == CLEAR ? 1'b0 : pend || (clear_req && state == DRAIN);
      range_err <= range_err || (accept && !in_range);
      cx        <= state != CLEAR || row_end ? '0 : cx + 1'b1;
      cy        <= state != CLEAR || last_px ? '0 : (row_end ? cy + 1'b1 : cy);
      plot      <= pop || state == CLEAR;
      if (pop) begin
        x      <= head.x;
        y      <= head.y;
        colour <= head.alive ? ALIVE_COLOUR : DEAD_COLOUR;
      end else if (state == CLEAR) begin
        x      <= cx;
        y      <= cy;
        colour <= DEAD_COLOUR;
      end
    end
endmodule
